sram_2p_march_bist: RTL and testbench

- Built-in self-test engine driving the BIST mux inputs of the 2-port SRAM macro (A_BIST_*/B_BIST_*) and checking its read data (A_DOUT/B_DOUT).
- Runs a March C- algorithm, one memory operation per clock.
- Compares read data one cycle after each read and reports pass/fail, first failing address and a saturating error count.
- Sits between the SoC test controller (START/DONE handshake) and the SRAM.

---
 rtl/sram_march_bist_pkg.sv | 53 +++++
 rtl/sram_march_bist_cmp.sv | 124 ++++++++++++
 rtl/sram_2p_march_bist.sv | 213 +++++++++++++++++++++
 tb/tb_sram_2p_march_bist.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_march_bist_pkg.sv
// Shared types and the March C- element table for the 2-port SRAM BIST.
// Contents:
//   state_e      - controller states (idle, run, drain, finish)
//   elem_idx_t   - March element index
//   elem_cfg_t   - per-element direction, op count, read/write polarities
//   elem_cfg()   - element table lookup
// Optional feature macro used by the files importing this package:
//   SRAM_MARCH_BIST_PORT_B_EN
package sram_march_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFinish
  } state_e;

  localparam int unsigned NUM_ELEMENTS = 6;

  typedef logic [2:0] elem_idx_t;

  // Polarity 0 selects the background pattern, 1 selects its inverse.
  typedef struct packed {
    logic       descending;
    logic [1:0] num_ops;        // 1 or 2 ops per address
    logic       first_is_read;  // with num_ops==2 the second op is always a write
    logic       read_pol;
    logic       write_pol;
  } elem_cfg_t;

  // March C-: {w0} up, {r0,w1} up, {r1,w0} up, {r0,w1} down, {r1,w0} down, {r0} up
  function automatic elem_cfg_t elem_cfg(elem_idx_t idx);
    elem_cfg_t cfg;
    cfg = '0;
    case (idx)
      3'd0: cfg = '{descending: 1'b0, num_ops: 2'd1, first_is_read: 1'b0,
                    read_pol: 1'b0, write_pol: 1'b0};
      3'd1: cfg = '{descending: 1'b0, num_ops: 2'd2, first_is_read: 1'b1,
                    read_pol: 1'b0, write_pol: 1'b1};
      3'd2: cfg = '{descending: 1'b0, num_ops: 2'd2, first_is_read: 1'b1,
                    read_pol: 1'b1, write_pol: 1'b0};
      3'd3: cfg = '{descending: 1'b1, num_ops: 2'd2, first_is_read: 1'b1,
                    read_pol: 1'b0, write_pol: 1'b1};
      3'd4: cfg = '{descending: 1'b1, num_ops: 2'd2, first_is_read: 1'b1,
                    read_pol: 1'b1, write_pol: 1'b0};
      3'd5: cfg = '{descending: 1'b0, num_ops: 2'd1, first_is_read: 1'b1,
                    read_pol: 1'b0, write_pol: 1'b0};
      default: cfg = '0;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/sram_march_bist_cmp.sv
// Read-data checker for the March BIST.
// A read issued in one cycle is registered here as {valid, expected, addr}; the SRAM
// data returned in the following cycle is compared against it and the sticky result
// registers are updated.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   clr_i              - clear fail flag, first-fail address and count
//   rd_i/exp_i/addr_i  - read issued this cycle, its expected data and address
//   dout_a_i           - SRAM port A read data
//   fail_o/fail_addr_o/fail_count_o - sticky fail, first failing address, saturating count
// With SRAM_MARCH_BIST_PORT_B_EN defined:
//   port_i             - port the read was issued on (0=A, 1=B)
//   dout_b_i           - SRAM port B read data
//   fail_port_o        - port of the first mismatch
module sram_march_bist_cmp #(
  parameter int unsigned DataWidth = 20,
  parameter int unsigned AddrWidth = 9,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 rd_i,
  input  logic [DataWidth-1:0] exp_i,
  input  logic [AddrWidth-1:0] addr_i,
`ifdef SRAM_MARCH_BIST_PORT_B_EN
  input  logic                 port_i,
  input  logic [DataWidth-1:0] dout_b_i,
  output logic                 fail_port_o,
`endif
  input  logic [DataWidth-1:0] dout_a_i,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [CntWidth-1:0]  fail_count_o
);

  logic                 stg_vld_q, stg_vld_d;
  logic [DataWidth-1:0] stg_exp_q, stg_exp_d;
  logic [AddrWidth-1:0] stg_addr_q, stg_addr_d;
  logic                 fail_q, fail_d;
  logic [AddrWidth-1:0] fail_addr_q, fail_addr_d;
  logic [CntWidth-1:0]  fail_count_q, fail_count_d;
  logic [DataWidth-1:0] dout;
  logic                 mismatch;

`ifdef SRAM_MARCH_BIST_PORT_B_EN
  logic stg_port_q, stg_port_d;
  logic fail_port_q, fail_port_d;

  // Select the data source by the port the pending read was issued on.
  assign dout        = stg_port_q ? dout_b_i : dout_a_i;
  assign fail_port_o = fail_port_q;
`else
  assign dout = dout_a_i;
`endif

  assign mismatch = stg_vld_q && (dout != stg_exp_q);

  always_comb begin
    stg_vld_d    = rd_i;
    stg_exp_d    = stg_exp_q;
    stg_addr_d   = stg_addr_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
    stg_port_d   = stg_port_q;
    fail_port_d  = fail_port_q;
    if (rd_i) stg_port_d = port_i;
`endif
    if (rd_i) begin
      stg_exp_d  = exp_i;
      stg_addr_d = addr_i;
    end
    if (clr_i) begin
      fail_d       = 1'b0;
      fail_addr_d  = '0;
      fail_count_d = '0;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
      fail_port_d  = 1'b0;
`endif
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = stg_addr_q;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
        fail_port_d = stg_port_q;
`endif
      end
      if (fail_count_q != '1) fail_count_d = fail_count_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_vld_q    <= 1'b0;
      stg_exp_q    <= '0;
      stg_addr_q   <= '0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
      stg_port_q   <= 1'b0;
      fail_port_q  <= 1'b0;
`endif
    end else begin
      stg_vld_q    <= stg_vld_d;
      stg_exp_q    <= stg_exp_d;
      stg_addr_q   <= stg_addr_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
      stg_port_q   <= stg_port_d;
      fail_port_q  <= fail_port_d;
`endif
    end
  end

  assign fail_o       = fail_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_count_o = fail_count_q;

endmodule

// File: rtl/sram_2p_march_bist.sv
// March C- BIST engine for the 2-port SRAM, one memory operation per clock.
// Ports:
//   CLK, RST_N                      - clock, asynchronous active-low reset
//   START/BUSY/DONE                 - test controller handshake
//   FAIL/FAIL_ADDR/FAIL_COUNT       - sticky result of the last run
//   A_BIST_* / A_DOUT               - SRAM port A BIST interface and read data
//   B_BIST_* / B_DOUT               - SRAM port B BIST interface and read data
// Optional feature macro SRAM_MARCH_BIST_PORT_B_EN: repeats the full sequence on port B
// after port A and adds FAIL_PORT (port of the first mismatch, 0=A, 1=B). Without it
// port B outputs are held at 0 and B_DOUT is ignored.
module sram_2p_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int unsigned             P_DATA_WIDTH     = 20,
  parameter int unsigned             P_ADDR_WIDTH     = 9,
  parameter logic [P_DATA_WIDTH-1:0] P_BG_PATTERN     = {P_DATA_WIDTH{1'b0}},
  parameter int unsigned             P_FAIL_CNT_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        START,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        FAIL,
  output logic [P_ADDR_WIDTH-1:0]     FAIL_ADDR,
  output logic [P_FAIL_CNT_WIDTH-1:0] FAIL_COUNT,
`ifdef SRAM_MARCH_BIST_PORT_B_EN
  output logic                        FAIL_PORT,
`endif
  output logic                        A_BIST_EN,
  output logic [P_ADDR_WIDTH-1:0]     A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0]     A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0]     A_BIST_BM,
  output logic                        A_BIST_MEN,
  output logic                        A_BIST_WEN,
  output logic                        A_BIST_REN,
  input  logic [P_DATA_WIDTH-1:0]     A_DOUT,
  output logic                        B_BIST_EN,
  output logic [P_ADDR_WIDTH-1:0]     B_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0]     B_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0]     B_BIST_BM,
  output logic                        B_BIST_MEN,
  output logic                        B_BIST_WEN,
  output logic                        B_BIST_REN,
  input  logic [P_DATA_WIDTH-1:0]     B_DOUT
);

  state_e                  state_q, state_d;
  elem_idx_t               elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    op_q, op_d;  // 0: first op at this address, 1: second op

`ifdef SRAM_MARCH_BIST_PORT_B_EN
  logic port_q, port_d;  // 0: sweeping port A, 1: sweeping port B
`else
  logic port_q;
  assign port_q = 1'b0;
`endif

  elem_cfg_t               cfg, nxt_cfg;
  logic                    is_read, last_op, elem_end, last_elem;
  logic                    run, active, a_sel, start_ok, rd_valid;
  logic [P_DATA_WIDTH-1:0] wr_data, rd_exp;

  // Decode the current operation from the element table.
  always_comb begin
    cfg       = elem_cfg(elem_q);
    nxt_cfg   = elem_cfg(elem_q + elem_idx_t'(1));
    is_read   = cfg.first_is_read && !op_q;
    last_op   = (cfg.num_ops == 2'd1) || op_q;
    elem_end  = cfg.descending ? (addr_q == '0) : (addr_q == '1);
    last_elem = (elem_q == elem_idx_t'(NUM_ELEMENTS - 1));
    wr_data   = cfg.write_pol ? ~P_BG_PATTERN : P_BG_PATTERN;
    rd_exp    = cfg.read_pol ? ~P_BG_PATTERN : P_BG_PATTERN;
  end

  assign run      = (state_q == StRun);
  assign active   = run || (state_q == StDrain);
  assign a_sel    = run && !port_q;
  assign start_ok = (state_q == StIdle) && START;
  assign rd_valid = run && is_read;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    op_d    = op_q;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
    port_d  = port_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StRun;
          elem_d  = '0;
          addr_d  = '0;
          op_d    = 1'b0;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
          port_d  = 1'b0;
`endif
        end
      end
      StRun: begin
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!elem_end) begin
            addr_d = cfg.descending ? addr_q - P_ADDR_WIDTH'(1) : addr_q + P_ADDR_WIDTH'(1);
          end else if (!last_elem) begin
            // Jump straight to the next element's start address, no idle cycle.
            elem_d = elem_q + elem_idx_t'(1);
            addr_d = nxt_cfg.descending ? '1 : '0;
          end else begin
`ifdef SRAM_MARCH_BIST_PORT_B_EN
            if (!port_q) begin
              port_d = 1'b1;
              elem_d = '0;
              addr_d = '0;
            end else begin
              state_d = StDrain;
            end
`else
            state_d = StDrain;
`endif
          end
        end
      end
      // One quiet cycle so the final read's data gets compared.
      StDrain:  state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      elem_q  <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
      port_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
      port_q  <= port_d;
`endif
    end
  end

  sram_march_bist_cmp #(
    .DataWidth (P_DATA_WIDTH),
    .AddrWidth (P_ADDR_WIDTH),
    .CntWidth  (P_FAIL_CNT_WIDTH)
  ) u_cmp (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .clr_i        (start_ok),
    .rd_i         (rd_valid),
    .exp_i        (rd_exp),
    .addr_i       (addr_q),
`ifdef SRAM_MARCH_BIST_PORT_B_EN
    .port_i       (port_q),
    .dout_b_i     (B_DOUT),
    .fail_port_o  (FAIL_PORT),
`endif
    .dout_a_i     (A_DOUT),
    .fail_o       (FAIL),
    .fail_addr_o  (FAIL_ADDR),
    .fail_count_o (FAIL_COUNT)
  );

  assign BUSY = active;
  assign DONE = (state_q == StFinish);

  // Port A keeps its BIST mux selected through the port B sweep.
  assign A_BIST_EN   = active;
  assign A_BIST_BM   = active ? '1 : '0;
  assign A_BIST_MEN  = a_sel;
  assign A_BIST_REN  = a_sel && is_read;
  assign A_BIST_WEN  = a_sel && !is_read;
  assign A_BIST_ADDR = a_sel ? addr_q : '0;
  assign A_BIST_DIN  = (a_sel && !is_read) ? wr_data : '0;

`ifdef SRAM_MARCH_BIST_PORT_B_EN
  logic b_act, b_sel;
  assign b_act       = active && port_q;
  assign b_sel       = run && port_q;
  assign B_BIST_EN   = b_act;
  assign B_BIST_BM   = b_act ? '1 : '0;
  assign B_BIST_MEN  = b_sel;
  assign B_BIST_REN  = b_sel && is_read;
  assign B_BIST_WEN  = b_sel && !is_read;
  assign B_BIST_ADDR = b_sel ? addr_q : '0;
  assign B_BIST_DIN  = (b_sel && !is_read) ? wr_data : '0;
`else
  logic unused_b_dout;
  assign unused_b_dout = ^B_DOUT;
  assign B_BIST_EN     = 1'b0;
  assign B_BIST_BM     = '0;
  assign B_BIST_MEN    = 1'b0;
  assign B_BIST_REN    = 1'b0;
  assign B_BIST_WEN    = 1'b0;
  assign B_BIST_ADDR   = '0;
  assign B_BIST_DIN    = '0;
`endif

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// Self-checking bench for sram_2p_march_bist: an ideal two-port SRAM with per-port read
// faults, and a reference that walks the March C- element list to predict the bus
// operations of every cycle and the resulting FAIL/FAIL_ADDR/FAIL_COUNT.
module tb_sram_2p_march_bist;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = 2;
  localparam int N  = 1 << AW;
  localparam logic [DW-1:0] BG = '0;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
  localparam int NPORTS = 2;
`else
  localparam int NPORTS = 1;
`endif
  localparam int RUN_LEN = 10 * N * NPORTS;

  logic          CLK = 1'b0;
  logic          RST_N, START;
  logic          BUSY, DONE, FAIL;
  logic [AW-1:0] FAIL_ADDR;
  logic [CW-1:0] FAIL_COUNT;
`ifdef SRAM_MARCH_BIST_PORT_B_EN
  logic          FAIL_PORT;
`endif
  logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
  logic [AW-1:0] A_BIST_ADDR;
  logic [DW-1:0] A_BIST_DIN, A_BIST_BM, A_DOUT;
  logic          B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN;
  logic [AW-1:0] B_BIST_ADDR;
  logic [DW-1:0] B_BIST_DIN, B_BIST_BM, B_DOUT;

  int tests_run    = 0;
  int tests_failed = 0;

  sram_2p_march_bist #(
    .P_DATA_WIDTH     (DW),
    .P_ADDR_WIDTH     (AW),
    .P_BG_PATTERN     (BG),
    .P_FAIL_CNT_WIDTH (CW)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .FAIL        (FAIL),
    .FAIL_ADDR   (FAIL_ADDR),
    .FAIL_COUNT  (FAIL_COUNT),
`ifdef SRAM_MARCH_BIST_PORT_B_EN
    .FAIL_PORT   (FAIL_PORT),
`endif
    .A_BIST_EN   (A_BIST_EN),
    .A_BIST_ADDR (A_BIST_ADDR),
    .A_BIST_DIN  (A_BIST_DIN),
    .A_BIST_BM   (A_BIST_BM),
    .A_BIST_MEN  (A_BIST_MEN),
    .A_BIST_WEN  (A_BIST_WEN),
    .A_BIST_REN  (A_BIST_REN),
    .A_DOUT      (A_DOUT),
    .B_BIST_EN   (B_BIST_EN),
    .B_BIST_ADDR (B_BIST_ADDR),
    .B_BIST_DIN  (B_BIST_DIN),
    .B_BIST_BM   (B_BIST_BM),
    .B_BIST_MEN  (B_BIST_MEN),
    .B_BIST_WEN  (B_BIST_WEN),
    .B_BIST_REN  (B_BIST_REN),
    .B_DOUT      (B_DOUT)
  );

  always #5 CLK = ~CLK;

  // Ideal shared array; faults act on each port's read data (force-0 / force-1 masks).
  logic [DW-1:0] mem [N];
  logic [DW-1:0] f0 [2][N];
  logic [DW-1:0] f1 [2][N];

  always @(posedge CLK) begin
    if (A_BIST_EN && A_BIST_MEN && A_BIST_WEN)
      mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
    if (A_BIST_EN && A_BIST_MEN && A_BIST_REN)
      A_DOUT <= (mem[A_BIST_ADDR] & ~f0[0][A_BIST_ADDR]) | f1[0][A_BIST_ADDR];
    if (B_BIST_EN && B_BIST_MEN && B_BIST_WEN)
      mem[B_BIST_ADDR] <= (mem[B_BIST_ADDR] & ~B_BIST_BM) | (B_BIST_DIN & B_BIST_BM);
    if (B_BIST_EN && B_BIST_MEN && B_BIST_REN)
      B_DOUT <= (mem[B_BIST_ADDR] & ~f0[1][B_BIST_ADDR]) | f1[1][B_BIST_ADDR];
  end

  // March C- as written on paper: direction and op list per element.
  localparam bit EL_DESC [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  string el_ops [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t trace[$];
  bit  exp_fail;
  int  exp_faddr;
  int  exp_cnt;
  bit  exp_port;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    logic [63:0] v;
    v = 64'({BUSY, DONE, FAIL, FAIL_ADDR, FAIL_COUNT,
             A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
             B_BIST_EN, B_BIST_ADDR, B_BIST_DIN, B_BIST_BM, B_BIST_MEN, B_BIST_WEN, B_BIST_REN});
`ifdef SRAM_MARCH_BIST_PORT_B_EN
    v = v | (64'(FAIL_PORT) << 60);
`endif
    return v;
  endfunction

  task automatic clear_faults();
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < N; a++) begin
        f0[p][a] = '0;
        f1[p][a] = '0;
      end
  endtask

  task automatic build_ref();
    logic [DW-1:0] m [N];
    logic [DW-1:0] v, obs;
    int            a;
    op_t           o;
    trace.delete();
    exp_fail  = 1'b0;
    exp_faddr = 0;
    exp_cnt   = 0;
    exp_port  = 1'b0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < N; k++) begin
          a = EL_DESC[e] ? N - 1 - k : k;
          for (int j = 0; j < el_ops[e].len(); j += 2) begin
            v      = (el_ops[e].getc(j + 1) == "1") ? ~BG : BG;
            o.port = (p != 0);
            o.addr = a[AW-1:0];
            o.data = v;
            o.we   = (el_ops[e].getc(j) == "w");
            if (o.we) begin
              m[a] = v;
            end else begin
              obs = (m[a] & ~f0[p][a]) | f1[p][a];
              if (obs !== v) begin
                if (!exp_fail) begin
                  exp_faddr = a;
                  exp_port  = (p != 0);
                end
                exp_fail = 1'b1;
                if (exp_cnt < (1 << CW) - 1) exp_cnt++;
              end
            end
            trace.push_back(o);
          end
        end
  endtask

  task automatic check_op(input string tag, input int i);
    op_t o;
    o = trace[i];
    chk($sformatf("%s c%0d busy/done", tag, i), 64'({BUSY, DONE}), 64'(2'b10));
    chk($sformatf("%s c%0d ctrlA", tag, i),
        64'({A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN}),
        64'({1'b1, !o.port, !o.port && o.we, !o.port && !o.we}));
    chk($sformatf("%s c%0d bmA", tag, i), 64'(A_BIST_BM), 64'({DW{1'b1}}));
    if (!o.port) begin
      chk($sformatf("%s c%0d addrA", tag, i), 64'(A_BIST_ADDR), 64'(o.addr));
      if (o.we) chk($sformatf("%s c%0d dinA", tag, i), 64'(A_BIST_DIN), 64'(o.data));
    end
`ifdef SRAM_MARCH_BIST_PORT_B_EN
    chk($sformatf("%s c%0d ctrlB", tag, i),
        64'({B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN}),
        64'({o.port, o.port, o.port && o.we, o.port && !o.we}));
    if (o.port) begin
      chk($sformatf("%s c%0d bmB", tag, i), 64'(B_BIST_BM), 64'({DW{1'b1}}));
      chk($sformatf("%s c%0d addrB", tag, i), 64'(B_BIST_ADDR), 64'(o.addr));
      if (o.we) chk($sformatf("%s c%0d dinB", tag, i), 64'(B_BIST_DIN), 64'(o.data));
    end
`else
    chk($sformatf("%s c%0d portB idle", tag, i),
        64'({B_BIST_EN, B_BIST_ADDR, B_BIST_DIN, B_BIST_BM, B_BIST_MEN, B_BIST_WEN, B_BIST_REN}),
        64'(0));
`endif
  endtask

  // One START-to-IDLE run; restart_at re-pulses START mid-run, reset_at aborts via RST_N.
  task automatic run_march(input string tag, input int restart_at, input int reset_at);
    bit aborted;
    build_ref();
    aborted = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < RUN_LEN && !aborted; i++) begin
      if (i == reset_at) begin
        RST_N = 1'b0;
        #1;
        chk({tag, " async reset outs"}, all_outs(), 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          chk($sformatf("%s post-reset idle %0d", tag, k), all_outs(), 64'(0));
        end
        aborted = 1'b1;
      end else begin
        START = (i == restart_at);
        check_op(tag, i);
        @(negedge CLK);
      end
    end
    START = 1'b0;
    if (!aborted) begin
      chk({tag, " drain busy/done"}, 64'({BUSY, DONE}), 64'(2'b10));
      chk({tag, " drain quiet"},
          64'({A_BIST_MEN, A_BIST_WEN, A_BIST_REN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN}),
          64'(0));
      @(negedge CLK);
      chk({tag, " finish busy/done/en"}, 64'({BUSY, DONE, A_BIST_EN, B_BIST_EN}),
          64'(4'b0100));
      chk({tag, " result"}, 64'({FAIL, FAIL_ADDR, FAIL_COUNT}),
          64'({exp_fail, exp_faddr[AW-1:0], exp_cnt[CW-1:0]}));
`ifdef SRAM_MARCH_BIST_PORT_B_EN
      chk({tag, " fail port"}, 64'(FAIL_PORT), 64'(exp_port));
`endif
      @(negedge CLK);
      chk({tag, " idle busy/done"}, 64'({BUSY, DONE}), 64'(0));
      chk({tag, " result held"}, 64'({FAIL, FAIL_ADDR, FAIL_COUNT}),
          64'({exp_fail, exp_faddr[AW-1:0], exp_cnt[CW-1:0]}));
    end
  endtask

  initial begin
    int nf, p, a, b, rs;
    clear_faults();
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    RST_N = 1'b0;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset outs", all_outs(), 64'(0));
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle outs", all_outs(), 64'(0));

    run_march("clean", -1, -1);

    clear_faults();
    f1[0][5] = 8'h01;
    run_march("a5_bit0_hi", -1, -1);
    chk("a5_bit0_hi plan", 64'({FAIL, FAIL_ADDR, FAIL_COUNT}), 64'({1'b1, 3'd5, 2'd3}));

    clear_faults();
    f0[0][6] = 8'h80;
    f0[0][2] = 8'h80;
    run_march("a2a6_bit7_lo", -1, -1);
    chk("a2a6_bit7_lo plan", 64'({FAIL, FAIL_ADDR, FAIL_COUNT}), 64'({1'b1, 3'd2, 2'd3}));

    clear_faults();
    run_march("restart20", 20, -1);

    clear_faults();
    f1[0][5] = 8'h01;
    run_march("reset37", -1, 37);

    clear_faults();
    run_march("after_reset", -1, -1);

`ifdef SRAM_MARCH_BIST_PORT_B_EN
    clear_faults();
    f1[1][4] = 8'h10;
    run_march("b4_only", -1, -1);
    chk("b4_only plan", 64'({FAIL, FAIL_PORT, FAIL_ADDR}), 64'({1'b1, 1'b1, 3'd4}));
`endif

    for (int t = 0; t < 8; t++) begin
      clear_faults();
      nf = int'($urandom_range(1, 3));
      for (int k = 0; k < nf; k++) begin
        p = int'($urandom_range(0, NPORTS - 1));
        a = int'($urandom_range(0, N - 1));
        b = int'($urandom_range(0, DW - 1));
        if ($urandom_range(0, 1) != 0) f1[p][a][b] = 1'b1;
        else                           f0[p][a][b] = 1'b1;
      end
      rs = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, RUN_LEN - 1)) : -1;
      run_march($sformatf("rand%0d", t), rs, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
